// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, centre-sampling FSM, valid/ready byte port with framing/overrun pulses.
// Optional UART_RX_MAJORITY_EN: 3-sample majority vote around every sample point (decisions one cycle later).
module uart_rx_core #(
  parameter int SYS_CLK_FREQ = 125000000,
  parameter int BAUD_RATE    = 115200
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_LENGTH_IN_CYCLES = SYS_CLK_FREQ / BAUD_RATE;
  localparam int HALF_BAUD             = BAUD_LENGTH_IN_CYCLES / 2;
  localparam int CNT_W                 = $clog2(BAUD_LENGTH_IN_CYCLES) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_LAST = HALF_BAUD;
`else
  localparam int START_LAST = HALF_BAUD - 1;
`endif
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_LAST);
  localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(BAUD_LENGTH_IN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;
  logic             sync1_q, rx_s;
  logic             sample;
  logic             done;

`ifdef UART_RX_MAJORITY_EN
  // rx_s history: at decision cycle N+1, rx_d1_q holds cycle N and rx_d2_q cycle N-1
  logic rx_d1_q, rx_d2_q;
  assign sample = (rx_s & rx_d1_q) | (rx_s & rx_d2_q) | (rx_d1_q & rx_d2_q);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    done      = 1'b0;

    if (valid_q && data_out_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == START_CNT) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d = '0;
          if (sample) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pending byte being consumed this cycle frees the slot for the new one
    if (done) begin
      if (!valid_q || data_out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s      <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_d1_q   <= 1'b1;
      rx_d2_q   <= 1'b1;
`endif
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync1_q   <= uart_rx;
      rx_s      <= sync1_q;
`ifdef UART_RX_MAJORITY_EN
      rx_d1_q   <= rx_s;
      rx_d2_q   <= rx_d1_q;
`endif
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign frame_err      = fe_q;
  assign overrun        = ov_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at a reduced bit period (24 cycles/bit, half = 12).
module tb_uart_rx_core;

  localparam int SYS = 2400;
  localparam int BR  = 100;
  localparam int B   = 24;
  localparam int HALF = 12;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 232;
`else
  localparam int LAT = 231;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_err;
  logic       overrun;

  uart_rx_core #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BR)) dut (
    .sysclk         (sysclk),
    .rst_n          (rst_n),
    .uart_rx        (uart_rx),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_err      (frame_err),
    .overrun        (overrun)
  );

  always #5 sysclk = ~sysclk;

  int         cyc = 0;
  logic [7:0] rx_mem [64];
  int         rx_n = 0;
  int         vld_cyc = 0;
  int         fe_cyc = 0;
  int         ov_cyc = 0;
  int         rise_cyc = 0;
  logic       vld_prev = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    vld_prev <= data_out_valid;
    if (data_out_valid) vld_cyc <= vld_cyc + 1;
    if (data_out_valid && !vld_prev) rise_cyc <= cyc;
    if (frame_err) fe_cyc <= fe_cyc + 1;
    if (overrun) ov_cyc <= ov_cyc + 1;
    if (data_out_valid && data_out_ready && rx_n < 64) begin
      rx_mem[rx_n] <= data_out;
      rx_n <= rx_n + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int cycles);
    uart_rx = v;
    repeat (cycles) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // glitch_bit >= 0 inserts a 1-cycle inverted pulse at the centre of that data bit
  task automatic send_byte(input logic [7:0] b, input logic stop, input int nstop, input int glitch_bit);
    drive(1'b0, B);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive(b[i], HALF);
        drive(~b[i], 1);
        drive(b[i], B - HALF - 1);
      end else begin
        drive(b[i], B);
      end
    end
    drive(stop, B * nstop);
  endtask

  int rd, s_vld, s_fe, s_ov, t0;
  logic [7:0] burst [4];

  task automatic snap();
    rd    = rx_n;
    s_vld = vld_cyc;
    s_fe  = fe_cyc;
    s_ov  = ov_cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    uart_rx = 1'b1;
    data_out_ready = 1'b1;
    burst[0] = 8'h55; burst[1] = 8'hAA; burst[2] = 8'h00; burst[3] = 8'hFF;
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, B);

    // Single byte with pin-level latency
    snap();
    t0 = cyc;
    send_byte(8'h41, 1'b1, 1, -1);
    drive(1'b1, 2 * B);
    check("t1_count", rx_n - rd, 1);
    check("t1_data", rx_mem[rd], 8'h41);
    check("t1_vld_cycles", vld_cyc - s_vld, 1);
    check("t1_latency", rise_cyc - t0, LAT);
    check("t1_fe", fe_cyc - s_fe, 0);
    check("t1_ov", ov_cyc - s_ov, 0);

    // False start, then a good frame
    snap();
    drive(1'b0, 5);
    drive(1'b1, B);
    check("t2_false_count", rx_n - rd, 0);
    check("t2_false_fe", fe_cyc - s_fe, 0);
    send_byte(8'h5A, 1'b1, 1, -1);
    drive(1'b1, 2 * B);
    check("t2_count", rx_n - rd, 1);
    check("t2_data", rx_mem[rd], 8'h5A);
    check("t2_ov", ov_cyc - s_ov, 0);

    // Framing error with a 3-bit break, then a good frame
    snap();
    send_byte(8'h41, 1'b0, 3, -1);
    drive(1'b1, 2 * B);
    check("t3_fe", fe_cyc - s_fe, 1);
    check("t3_none", rx_n - rd, 0);
    check("t3_vld", vld_cyc - s_vld, 0);
    send_byte(8'h33, 1'b1, 1, -1);
    drive(1'b1, 2 * B);
    check("t3_count", rx_n - rd, 1);
    check("t3_data", rx_mem[rd], 8'h33);

    // Overrun while the consumer stalls
    data_out_ready = 1'b0;
    snap();
    send_byte(8'h41, 1'b1, 1, -1);
    send_byte(8'h7E, 1'b1, 1, -1);
    drive(1'b1, B);
    check("t4_ov", ov_cyc - s_ov, 1);
    check("t4_held_data", data_out, 8'h41);
    check("t4_held_valid", data_out_valid, 1'b1);
    check("t4_fe", fe_cyc - s_fe, 0);
    data_out_ready = 1'b1;
    drive(1'b1, 2);
    check("t4_count", rx_n - rd, 1);
    check("t4_data", rx_mem[rd], 8'h41);
    check("t4_valid_clr", data_out_valid, 1'b0);

    // Back-to-back burst
    snap();
    for (int i = 0; i < 4; i++) send_byte(burst[i], 1'b1, 1, -1);
    drive(1'b1, 2 * B);
    check("t5_count", rx_n - rd, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t5_data%0d", i), rx_mem[rd + i], burst[i]);
    check("t5_vld_cycles", vld_cyc - s_vld, 4);
    check("t5_fe", fe_cyc - s_fe, 0);
    check("t5_ov", ov_cyc - s_ov, 0);

    // Reset in the middle of the data bits
    drive(1'b0, B);
    drive(1'b1, B);
    drive(1'b0, B);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    #1;
    check("t6_rst_data", data_out, 8'h00);
    check("t6_rst_valid", data_out_valid, 1'b0);
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2 * B);
    snap();
    send_byte(8'hC3, 1'b1, 1, -1);
    drive(1'b1, 2 * B);
    check("t6_count", rx_n - rd, 1);
    check("t6_data", rx_mem[rd], 8'hC3);
    check("t6_fe", fe_cyc - s_fe, 0);

`ifdef UART_RX_MAJORITY_EN
    snap();
    send_byte(8'h41, 1'b1, 1, 3);
    drive(1'b1, 2 * B);
    check("t7_count", rx_n - rd, 1);
    check("t7_glitch_data", rx_mem[rd], 8'h41);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
